// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: FU encodings, default
// writeback latencies and the number of functional-unit slots.
package reg_scoreboard_pkg;

    localparam int NUM_FU = 4;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MEM = 2'd1,
        FU_MUL = 2'd2,
        FU_DIV = 2'd3
    } fu_e;

    localparam int DEF_LAT_ALU = 1;
    localparam int DEF_LAT_MEM = 2;
    localparam int DEF_LAT_MUL = 4;
    localparam int DEF_LAT_DIV = 8;

endpackage

// File: rtl/sb_fu_slot.sv
// One in-flight slot of the scoreboard: holds destination register and a
// countdown to writeback eligibility for a single functional unit.
module sb_fu_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] load_rd,
    input  logic [3:0] load_cnt,
    input  logic       grant,
    output logic       valid,
    output logic [4:0] rd,
    output logic [3:0] cnt
);

    // load only arrives while the slot is empty and grant only while it is
    // full, so the two never collide; cnt saturates at 0 while awaiting grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            rd    <= 5'd0;
            cnt   <= 4'd0;
        end else if (load) begin
            valid <= 1'b1;
            rd    <= load_rd;
            cnt   <= load_cnt;
        end else if (grant) begin
            valid <= 1'b0;
        end else if (valid && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard: detects RAW/WAW/structural hazards at issue and
// arbitrates one writeback per cycle among four fixed-latency FU slots.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int LAT_ALU = DEF_LAT_ALU,
    parameter int LAT_MEM = DEF_LAT_MEM,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_DIV = DEF_LAT_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [1:0]  issue_fu,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1use_ID,
    input  logic        rs2use_ID,
    output logic        issue_ready,
    output logic        stall_raw,
    output logic        stall_waw,
    output logic        stall_struct,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_fu,
    output logic [31:0] busy_vec
);

    logic [NUM_FU-1:0] slot_valid;
    logic [4:0]        slot_rd  [NUM_FU];
    logic [3:0]        slot_cnt [NUM_FU];
    logic [NUM_FU-1:0] slot_load;
    logic [NUM_FU-1:0] slot_grant;
    logic [3:0]        load_cnt;
    logic              accept;

    function automatic logic [3:0] lat_m1(input logic [1:0] fu);
        case (fu)
            FU_ALU:  return 4'(LAT_ALU - 1);
            FU_MEM:  return 4'(LAT_MEM - 1);
            FU_MUL:  return 4'(LAT_MUL - 1);
            default: return 4'(LAT_DIV - 1);
        endcase
    endfunction

    // Handshake: an instruction is taken on a rising edge where issue_valid
    // and issue_ready are both high. issue_ready depends only on slot state
    // and the ID-stage fields, never on issue_valid, so ID may sample it freely.
    always_comb begin
        busy_vec = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (slot_valid[f]) busy_vec[slot_rd[f]] = 1'b1;
        end
        busy_vec[0] = 1'b0;
    end

    always_comb begin
        stall_raw    = (rs1use_ID && rs1_ID != 5'd0 && busy_vec[rs1_ID]) ||
                       (rs2use_ID && rs2_ID != 5'd0 && busy_vec[rs2_ID]);
        stall_waw    = (issue_rd != 5'd0) && busy_vec[issue_rd];
        stall_struct = slot_valid[issue_fu];
        issue_ready  = !(stall_raw || stall_waw || stall_struct);
        accept       = issue_valid && issue_ready;
        load_cnt     = lat_m1(issue_fu);
        slot_load    = '0;
        if (accept) slot_load[issue_fu] = 1'b1;
    end

    // Fixed priority: scanning from the top down leaves the lowest index.
    always_comb begin
        wb_valid   = 1'b0;
        wb_rd      = 5'd0;
        wb_fu      = 2'd0;
        slot_grant = '0;
        for (int f = NUM_FU - 1; f >= 0; f--) begin
            if (slot_valid[f] && slot_cnt[f] == 4'd0) begin
                wb_valid = 1'b1;
                wb_rd    = slot_rd[f];
                wb_fu    = 2'(f);
            end
        end
        if (wb_valid) slot_grant[wb_fu] = 1'b1;
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
        sb_fu_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (slot_load[g]),
            .load_rd  (issue_rd),
            .load_cnt (load_cnt),
            .grant    (slot_grant[g]),
            .valid    (slot_valid[g]),
            .rd       (slot_rd[g]),
            .cnt      (slot_cnt[g])
        );
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios followed by random issue
// traffic, all checked against a cycle-stamped reference model.
module tb_reg_scoreboard;

    localparam int NUM_FU = 4;
    localparam int LAT [NUM_FU] = '{1, 2, 4, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_fu = 2'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic [4:0]  rs1_ID = 5'd0;
    logic [4:0]  rs2_ID = 5'd0;
    logic        rs1use_ID = 1'b0;
    logic        rs2use_ID = 1'b0;
    logic        issue_ready, stall_raw, stall_waw, stall_struct;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_fu;
    logic [31:0] busy_vec;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: each FU holds at most one op, eligible for writeback
    // from absolute cycle m_due onward.
    logic       m_valid [NUM_FU];
    logic [4:0] m_rd    [NUM_FU];
    int         m_due   [NUM_FU];
    logic [6:0] exp_q[$];

    reg_scoreboard #(
        .LAT_ALU(1), .LAT_MEM(2), .LAT_MUL(4), .LAT_DIV(8)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_rd(issue_rd),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .issue_ready(issue_ready), .stall_raw(stall_raw), .stall_waw(stall_waw),
        .stall_struct(stall_struct), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_fu(wb_fu), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int f = 0; f < NUM_FU; f++) begin
            m_valid[f] = 1'b0;
            m_rd[f]    = 5'd0;
            m_due[f]   = 0;
        end
        exp_q.delete();
    endtask

    // Called just after a rising edge; checks mid-cycle, returns just after the next edge.
    task automatic step(input logic v, input logic [1:0] fu, input logic [4:0] rd,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
        logic [31:0] e_busy;
        logic        e_raw, e_waw, e_str, e_rdy, e_wbv;
        logic [4:0]  e_wbrd;
        logic [1:0]  e_wbfu;
        int          hit;
        issue_valid = v;  issue_fu = fu;  issue_rd = rd;
        rs1_ID = r1;  rs1use_ID = u1;  rs2_ID = r2;  rs2use_ID = u2;
        #3;
        e_busy = '0;
        for (int f = 0; f < NUM_FU; f++)
            if (m_valid[f] && m_rd[f] != 5'd0) e_busy[m_rd[f]] = 1'b1;
        e_raw = (u1 && r1 != 0 && e_busy[r1]) || (u2 && r2 != 0 && e_busy[r2]);
        e_waw = (rd != 0) && e_busy[rd];
        e_str = m_valid[fu];
        e_rdy = !(e_raw || e_waw || e_str);
        e_wbv = 1'b0;  e_wbrd = 5'd0;  e_wbfu = 2'd0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (!e_wbv && m_valid[f] && cyc >= m_due[f]) begin
                e_wbv = 1'b1;  e_wbrd = m_rd[f];  e_wbfu = 2'(f);
            end
        end
        chk("busy_vec", busy_vec, e_busy);
        chk("stall_raw", 32'(stall_raw), 32'(e_raw));
        chk("stall_waw", 32'(stall_waw), 32'(e_waw));
        chk("stall_struct", 32'(stall_struct), 32'(e_str));
        chk("issue_ready", 32'(issue_ready), 32'(e_rdy));
        chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
        chk("wb_rd", 32'(wb_rd), 32'(e_wbrd));
        chk("wb_fu", 32'(wb_fu), 32'(e_wbfu));
        if (wb_valid === 1'b1) begin
            hit = -1;
            foreach (exp_q[i]) if (hit < 0 && exp_q[i] == {wb_fu, wb_rd}) hit = i;
            chk("wb_expected", 32'(hit >= 0), 32'd1);
            if (hit >= 0) exp_q.delete(hit);
        end
        @(posedge clk);
        if (e_wbv) m_valid[e_wbfu] = 1'b0;
        if (v && e_rdy) begin
            m_valid[fu] = 1'b1;
            m_rd[fu]    = rd;
            m_due[fu]   = cyc + 1 + LAT[fu] - 1;
            exp_q.push_back({fu, rd});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic mid_reset();
        issue_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy_vec", busy_vec, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_fu", 32'(wb_fu), 32'd0);
        @(posedge clk);
        cyc++;
        #1 rst = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy_vec", busy_vec, 32'd0);
        chk("reset_ready", 32'(issue_ready), 32'd1);

        // ALU rd=5: writeback next cycle, busy gone the cycle after
        step(1'b1, 2'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(2);
        // DIV rd=7 then a dependent reader held through the writeback cycle
        step(1'b1, 2'd3, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 5'd1, 5'd7, 1'b1, 5'd0, 1'b0);
        // MUL rd=3 and ALU rd=4 reach writeback together; ALU wins
        step(1'b1, 2'd2, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(2);
        step(1'b1, 2'd0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(3);
        // Back-to-back MEM issues; second waits on the slot, then a WAW on rd=10
        step(1'b1, 2'd1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 2'd0, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(3);
        // rd=0 occupies the slot and writes back without touching busy_vec
        step(1'b1, 2'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step(1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        idle(1);
        // Reset while DIV rd=12 is in flight discards it
        step(1'b1, 2'd3, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(2);
        mid_reset();
        step(1'b1, 2'd3, 5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
        idle(10);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) mid_reset();
            step(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        idle(12);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
